// File: rtl/lru_matrix_ctrl.sv
// Matrix-LRU replacement controller: one NUM_WAYS x NUM_WAYS age matrix per index,
// post-reset clear sweep, RMW updates with forwarding. Optional way locking under LRU_LOCK_EN.
module lru_matrix_ctrl #(
  parameter  int NUM_WAYS    = 4,
  parameter  int INDEX_WIDTH = 6,
  localparam int WAY_W       = $clog2(NUM_WAYS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   init_busy_o,
  input  logic                   req_valid_i,
  input  logic [INDEX_WIDTH-1:0] req_index_i,
  output logic                   victim_valid_o,
  output logic [WAY_W-1:0]       victim_way_o,
  input  logic                   upd_valid_i,
  input  logic                   upd_inv_i,
  input  logic [INDEX_WIDTH-1:0] upd_index_i,
  input  logic [WAY_W-1:0]       upd_way_i,
  input  logic [NUM_WAYS-1:0]    lock_mask_i
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;
  localparam int MAT_W = NUM_WAYS * NUM_WAYS;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [INDEX_WIDTH-1:0] pend_index_q, pend_index_d;
  logic [MAT_W-1:0]       pend_data_q, pend_data_d;
  logic                   victim_valid_q, victim_valid_d;
  logic [WAY_W-1:0]       victim_way_q, victim_way_d;
  logic [MAT_W-1:0]       mem_q [DEPTH];

  logic [MAT_W-1:0]       req_mat_s;
  logic [MAT_W-1:0]       upd_mat_s;
  logic [MAT_W-1:0]       new_mat_s;
  logic [NUM_WAYS-1:0]    lk_s;
  logic [WAY_W:0]         pick_s;
  logic                   found_s;

  // Touch makes way w MRU (row ones, column cleared); invalidate makes it LRU (row zero, column set).
  function automatic logic [MAT_W-1:0] apply_update(input logic [MAT_W-1:0] m,
                                                    input logic inv,
                                                    input logic [WAY_W-1:0] w);
    logic [MAT_W-1:0] r;
    r = m;
    for (int row = 0; row < NUM_WAYS; row++) begin
      for (int col = 0; col < NUM_WAYS; col++) begin
        if (row == int'(w)) begin
          r[row*NUM_WAYS+col] = (col != int'(w)) && !inv;
        end else if (col == int'(w)) begin
          r[row*NUM_WAYS+col] = inv;
        end else begin
          r[row*NUM_WAYS+col] = m[row*NUM_WAYS+col];
        end
      end
    end
    return r;
  endfunction

  // Returns {found, way}: lowest unlocked way whose row, masked to unlocked columns, is zero.
  function automatic logic [WAY_W:0] pick_victim(input logic [MAT_W-1:0] m,
                                                 input logic [NUM_WAYS-1:0] lk);
    logic             found;
    logic [WAY_W-1:0] way;
    found = 1'b0;
    way   = '0;
    for (int r = NUM_WAYS - 1; r >= 0; r--) begin
      if (!lk[r] && ((m[r*NUM_WAYS +: NUM_WAYS] & ~lk) == '0)) begin
        found = 1'b1;
        way   = WAY_W'(r);
      end else begin
        found = found;
      end
    end
    return {found, way};
  endfunction

`ifdef LRU_LOCK_EN
  assign lk_s    = lock_mask_i;
  assign found_s = pick_s[WAY_W];
`else
  logic lock_unused_s;
  assign lock_unused_s = ^lock_mask_i;
  assign lk_s          = '0;
  assign found_s       = 1'b1;
`endif

  // Reads see the not-yet-retired pending write so back-to-back updates chain.
  assign req_mat_s = (pend_valid_q && (pend_index_q == req_index_i)) ? pend_data_q : mem_q[req_index_i];
  assign upd_mat_s = (pend_valid_q && (pend_index_q == upd_index_i)) ? pend_data_q : mem_q[upd_index_i];
  assign new_mat_s = apply_update(upd_mat_s, upd_inv_i, upd_way_i);
  assign pick_s    = pick_victim(req_mat_s, lk_s);

  // Next-state logic for sweep, pending-write stage and victim output.
  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    pend_valid_d   = 1'b0;
    pend_index_d   = pend_index_q;
    pend_data_d    = pend_data_q;
    victim_valid_d = 1'b0;
    victim_way_d   = '0;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + INDEX_WIDTH'(1);
        if (sweep_q == INDEX_WIDTH'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (req_valid_i) begin
          victim_valid_d = found_s;
          victim_way_d   = found_s ? pick_s[WAY_W-1:0] : '0;
        end else begin
          victim_valid_d = 1'b0;
        end
        if (upd_valid_i) begin
          pend_valid_d = 1'b1;
          pend_index_d = upd_index_i;
          pend_data_d  = new_mat_s;
        end else begin
          pend_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Control and output registers; reset restarts the sweep and drops any pending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_INIT;
      sweep_q        <= '0;
      pend_valid_q   <= 1'b0;
      pend_index_q   <= '0;
      pend_data_q    <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      pend_valid_q   <= pend_valid_d;
      pend_index_q   <= pend_index_d;
      pend_data_q    <= pend_data_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  // Matrix storage: cleared by the sweep during INIT, pending stage retires during RUN.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[sweep_q] <= '0;
    end else if (pend_valid_q) begin
      mem_q[pend_index_q] <= pend_data_q;
    end
  end

  assign init_busy_o    = (state_q == ST_INIT);
  assign victim_valid_o = victim_valid_q;
  assign victim_way_o   = victim_way_q;

endmodule

// File: tb/tb_lru_matrix_ctrl.sv
// Bench for lru_matrix_ctrl: recency timestamps per way as reference, scoreboard queue
// filled by the driver and drained on schedule by an independent monitor.
module tb_lru_matrix_ctrl;
  localparam int NW    = 4;
  localparam int IW    = 6;
  localparam int WW    = 2;
  localparam int DEPTH = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          init_busy_o;
  logic          req_valid_i = 1'b0;
  logic [IW-1:0] req_index_i = '0;
  logic          victim_valid_o;
  logic [WW-1:0] victim_way_o;
  logic          upd_valid_i = 1'b0;
  logic          upd_inv_i = 1'b0;
  logic [IW-1:0] upd_index_i = '0;
  logic [WW-1:0] upd_way_i = '0;
  logic [NW-1:0] lock_mask_i = '0;

  lru_matrix_ctrl #(.NUM_WAYS(NW), .INDEX_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .init_busy_o(init_busy_o),
    .req_valid_i(req_valid_i), .req_index_i(req_index_i),
    .victim_valid_o(victim_valid_o), .victim_way_o(victim_way_o),
    .upd_valid_i(upd_valid_i), .upd_inv_i(upd_inv_i), .upd_index_i(upd_index_i),
    .upd_way_i(upd_way_i), .lock_mask_i(lock_mask_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int ecyc; logic ev; int ew; } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit run_ph = 1'b0;
  int ts[DEPTH][NW];
  int hi_stamp = 0;
  int lo_stamp = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference: each way carries a recency stamp; LRU is the smallest stamp among unlocked ways.
  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < NW; w++) ts[i][w] = 0;
  endfunction

  function automatic void model_update(input int idx, input bit inv, input int w);
    if (inv) begin
      lo_stamp--;
      ts[idx][w] = lo_stamp;
    end else begin
      hi_stamp++;
      ts[idx][w] = hi_stamp;
    end
  endfunction

  function automatic void model_victim(input int idx, input logic [NW-1:0] lk, output logic v, output int w);
    logic [NW-1:0] eff;
    int best;
`ifdef LRU_LOCK_EN
    eff = lk;
`else
    eff = '0;
`endif
    v = 1'b0;
    best = 0;
    for (int c = 0; c < NW; c++) begin
      if (!eff[c] && (!v || ts[idx][c] < ts[idx][best])) begin
        best = c;
        v = 1'b1;
      end
    end
    w = v ? best : 0;
  endfunction

  task automatic drive(input bit rq, input int ri, input bit up, input bit inv,
                       input int ui, input int uw, input logic [NW-1:0] lk);
    logic v;
    int w;
    @(negedge clk_i);
    req_valid_i = rq;
    req_index_i = IW'(ri);
    upd_valid_i = up;
    upd_inv_i   = inv;
    upd_index_i = IW'(ui);
    upd_way_i   = WW'(uw);
    lock_mask_i = lk;
    if (run_ph && rq) begin
      model_victim(ri, lk, v, w);
      exp_q.push_back('{ecyc: cyc + 1, ev: v, ew: w});
    end
    if (run_ph && up) model_update(ui, inv, uw);
  endtask

  task automatic set_idle();
    req_valid_i = 1'b0;
    upd_valid_i = 1'b0;
    upd_inv_i   = 1'b0;
    lock_mask_i = '0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Releases reset, hammers ignored traffic during the sweep, and measures its length.
  task automatic release_and_count();
    int n;
    n = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    while (init_busy_o === 1'b1 && n < 200) begin
      n++;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b1;
      req_index_i = IW'($urandom);
      upd_valid_i = 1'b1;
      upd_inv_i   = 1'($urandom);
      upd_index_i = IW'($urandom);
      upd_way_i   = WW'($urandom);
    end
    set_idle();
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL init_len: busy for %0d cycles, expected %0d", n, DEPTH);
    end
    run_ph = 1'b1;
  endtask

  // Monitor: pops the entry scheduled for this cycle, otherwise requires no victim_valid.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0 && exp_q[0].ecyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (victim_valid_o !== e.ev || victim_way_o !== WW'(e.ew)) begin
          errors++;
          $display("FAIL victim cyc=%0d: got valid=%b way=%0d, expected valid=%b way=%0d",
                   cyc, victim_valid_o, victim_way_o, e.ev, e.ew);
        end
      end else begin
        checks++;
        if (victim_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_valid cyc=%0d: got valid=%b, expected 0", cyc, victim_valid_o);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk_i);
    check_bit("reset_busy", init_busy_o, 1'b1);
    check_bit("reset_valid", victim_valid_o, 1'b0);
    checks++;
    if (victim_way_o !== '0) begin
      errors++;
      $display("FAIL reset_way: got %0d, expected 0", victim_way_o);
    end
    release_and_count();

    for (int i = 0; i < 8; i++) drive(1'b1, $urandom_range(0, DEPTH - 1), 1'b0, 1'b0, 0, 0, '0);

    for (int w = 0; w < NW; w++) drive(1'b0, 0, 1'b1, 1'b0, 5, w, '0);
    drive(1'b1, 5, 1'b0, 1'b0, 0, 0, '0);
    drive(1'b0, 0, 1'b1, 1'b0, 5, 0, '0);
    drive(1'b1, 5, 1'b0, 1'b0, 0, 0, '0);

    for (int w = 0; w < NW; w++) drive(1'b0, 0, 1'b1, 1'b0, 9, w, '0);
    drive(1'b0, 0, 1'b1, 1'b1, 9, 2, '0);
    drive(1'b1, 9, 1'b0, 1'b0, 0, 0, '0);
    drive(1'b0, 0, 1'b1, 1'b0, 9, 2, '0);
    drive(1'b1, 9, 1'b0, 1'b0, 0, 0, '0);

    drive(1'b1, 3, 1'b1, 1'b0, 3, 0, '0);
    drive(1'b1, 3, 1'b0, 1'b0, 0, 0, '0);

    for (int i = 0; i < 600; i++) begin
      int ri, ui;
      ri = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3);
      ui = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3);
      drive(1'($urandom), ri, 1'($urandom), ($urandom_range(0, 4) == 0), ui,
            $urandom_range(0, NW - 1), NW'($urandom));
    end

    drive(1'b1, 11, 1'b1, 1'b0, 11, 1, '0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    run_ph = 1'b0;
    set_idle();
    #1;
    check_bit("rst_async_valid", victim_valid_o, 1'b0);
    check_bit("rst_busy", init_busy_o, 1'b1);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_bit("midsweep_busy", init_busy_o, 1'b1);
    check_bit("midsweep_valid", victim_valid_o, 1'b0);
    repeat (2) @(negedge clk_i);
    release_and_count();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 1'b0, 1'b0, 0, 0, '0);

`ifdef LRU_LOCK_EN
    for (int w = 0; w < NW; w++) drive(1'b0, 0, 1'b1, 1'b0, 7, w, '0);
    drive(1'b1, 7, 1'b0, 1'b0, 0, 0, 4'b0001);
    drive(1'b1, 7, 1'b0, 1'b0, 0, 0, 4'b1111);
    drive(1'b1, 7, 1'b1, 1'b0, 7, 1, 4'b0011);
    drive(1'b1, 7, 1'b0, 1'b0, 0, 0, 4'b0001);
`endif

    drive(1'b0, 0, 1'b0, 1'b0, 0, 0, '0);
    repeat (4) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
